// File: rtl/led_status_ctrl_if.sv
// Bus bundle for led_status_ctrl: per-channel mode/activity inputs, global
// PWM duty, and the registered LED drive plus heartbeat tick coming back.
interface led_status_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 4
);
  logic [2*NUM_CH-1:0] ch_mode;
  logic [NUM_CH-1:0]   ch_act;
  logic [PWM_W-1:0]    pwm_duty;
  logic [NUM_CH-1:0]   led_out;
  logic                hb_tick;

  modport master (
    output ch_mode, ch_act, pwm_duty,
    input  led_out, hb_tick
  );

  modport slave (
    input  ch_mode, ch_act, pwm_duty,
    output led_out, hb_tick
  );
endinterface

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel status LED / PMOD driver.
// A shared free-running heartbeat counter provides the blink phase and a
// wrap tick; each channel picks off / on / blink / stretched-activity.
// Activity mode stretches short pulses into visible ON windows of
// STRETCH_CYC cycles separated by GAP windows of the same length.
// Optional feature macro: LED_PWM_EN adds global PWM brightness gating.

// Per-channel activity FSM and output register.
module led_status_ch #(
  parameter int STRETCH_CYC = 6250000
) (
  input  logic       bd_fclk0_125m,
  input  logic       bd_aresetn,
  input  logic [1:0] mode,
  input  logic       act,
  input  logic       blink,
  input  logic       gate,
  output logic       led
);
  localparam int TW = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(STRETCH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } st_t;

  st_t          st;
  logic [TW-1:0] timer;
  logic         pend;
  logic         base;

  // Output source select from the current mode and current FSM state.
  always_comb begin
    base = 1'b0;
    case (mode)
      2'b00:   base = 1'b0;
      2'b01:   base = 1'b1;
      2'b10:   base = blink;
      default: base = (st == ST_ON);
    endcase
  end

  // Activity stretcher: ON then GAP, each STRETCH_CYC long; a request seen
  // during GAP (including its last cycle) chains straight into a new ON.
  // Requests during ON are dropped so the window is never extended.
  always_ff @(posedge bd_fclk0_125m or negedge bd_aresetn) begin
    if (!bd_aresetn) begin
      st    <= ST_IDLE;
      timer <= '0;
      pend  <= 1'b0;
    end else if (mode != 2'b11) begin
      st    <= ST_IDLE;
      timer <= '0;
      pend  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (act) begin
            st    <= ST_ON;
            timer <= RELOAD;
          end
        end
        ST_ON: begin
          if (timer == '0) begin
            st    <= ST_GAP;
            timer <= RELOAD;
            pend  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            st    <= (pend || act) ? ST_ON : ST_IDLE;
            timer <= (pend || act) ? RELOAD : '0;
            pend  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
            if (act) pend <= 1'b1;
          end
        end
        default: begin
          st    <= ST_IDLE;
          timer <= '0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

  // Registered LED drive; PWM gate is applied ahead of the flop so the
  // mode-to-output latency stays at one cycle.
  always_ff @(posedge bd_fclk0_125m or negedge bd_aresetn) begin
    if (!bd_aresetn) led <= 1'b0;
    else             led <= base & gate;
  end
endmodule

module led_status_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int STRETCH_CYC = 6250000,
  parameter int PWM_W       = 4
) (
  input  logic             bd_fclk0_125m,
  input  logic             bd_aresetn,
  led_status_ctrl_if.slave bus
);
  logic [CNT_W-1:0]             hb_cnt;
  logic                         hb_tick_q;
  logic                         pwm_gate;
  logic [NUM_CH-1:0][1:0]       mode_v;
  logic [NUM_CH-1:0]            led_q;

  assign mode_v = bus.ch_mode;

  // Heartbeat counter; the tick flop goes high exactly when the counter
  // has just wrapped to zero, so it never fires on the first post-reset cycle.
  always_ff @(posedge bd_fclk0_125m or negedge bd_aresetn) begin
    if (!bd_aresetn) begin
      hb_cnt    <= '0;
      hb_tick_q <= 1'b0;
    end else begin
      hb_cnt    <= hb_cnt + 1'b1;
      hb_tick_q <= &hb_cnt;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // Free-running PWM phase counter.
  always_ff @(posedge bd_fclk0_125m or negedge bd_aresetn) begin
    if (!bd_aresetn) pwm_cnt <= '0;
    else             pwm_cnt <= pwm_cnt + 1'b1;
  end

  // All-ones duty forces full on; otherwise on for the first duty phases.
  assign pwm_gate = (pwm_cnt < bus.pwm_duty) | (&bus.pwm_duty);
`else
  logic unused_pwm;
  assign unused_pwm = ^bus.pwm_duty;
  assign pwm_gate   = 1'b1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_status_ch #(
      .STRETCH_CYC (STRETCH_CYC)
    ) u_ch (
      .bd_fclk0_125m (bd_fclk0_125m),
      .bd_aresetn    (bd_aresetn),
      .mode          (mode_v[g]),
      .act           (bus.ch_act[g]),
      .blink         (hb_cnt[CNT_W-1]),
      .gate          (pwm_gate),
      .led           (led_q[g])
    );
  end

  assign bus.led_out = led_q;
  assign bus.hb_tick = hb_tick_q;
endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl. The driver steps a cycle-indexed
// reference model (activity windows described by their start edge) and
// pushes the expected post-edge outputs; a monitor pops and compares on
// every falling edge.
module tb_led_status_ctrl;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 4;
  localparam int STRETCH_CYC = 4;
  localparam int PWM_W       = 4;
  localparam int HB          = 1 << CNT_W;
  localparam int PW          = 1 << PWM_W;

  logic bd_fclk0_125m = 1'b0;
  logic bd_aresetn    = 1'b0;

  led_status_ctrl_if #(.NUM_CH(NUM_CH), .PWM_W(PWM_W)) bus ();

  led_status_ctrl #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .STRETCH_CYC (STRETCH_CYC),
    .PWM_W       (PWM_W)
  ) dut (
    .bd_fclk0_125m (bd_fclk0_125m),
    .bd_aresetn    (bd_aresetn),
    .bus           (bus)
  );

  always #5 bd_fclk0_125m = ~bd_fclk0_125m;

  typedef struct {
    logic [NUM_CH-1:0] led;
    logic              tick;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: edges since reset release, and per channel the
  // edge at which the current ON window began (-1 = idle) plus whether a
  // request arrived inside the following GAP window.
  int e;
  int act_start [NUM_CH];
  bit act_seen  [NUM_CH];

  task automatic model_reset();
    e = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      act_start[c] = -1;
      act_seen[c]  = 1'b0;
    end
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_edge();
    exp_t     x;
    int       md, age;
    bit       on_prev, base, gate, a;
    gate = 1'b1;
`ifdef LED_PWM_EN
    gate = ((e % PW) < int'(bus.pwm_duty)) || (int'(bus.pwm_duty) == PW - 1);
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      md      = int'(bus.ch_mode[2*c +: 2]);
      on_prev = (act_start[c] >= 0) && ((e - act_start[c]) < STRETCH_CYC);
      case (md)
        0:       base = 1'b0;
        1:       base = 1'b1;
        2:       base = ((e % HB) >= HB/2);
        default: base = on_prev;
      endcase
      x.led[c] = base & gate;
    end
    e = e + 1;
    x.tick = ((e % HB) == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      md = int'(bus.ch_mode[2*c +: 2]);
      a  = bus.ch_act[c];
      if (md != 3) begin
        act_start[c] = -1;
        act_seen[c]  = 1'b0;
      end else if (act_start[c] < 0) begin
        if (a) act_start[c] = e;
      end else begin
        age = e - act_start[c];
        if (age == 2*STRETCH_CYC) begin
          act_start[c] = (act_seen[c] || a) ? e : -1;
          act_seen[c]  = 1'b0;
        end else if (age > STRETCH_CYC && a) begin
          act_seen[c] = 1'b1;
        end
      end
    end
    sb.push_back(x);
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge bd_fclk0_125m);
      model_edge();
      #1;
    end
  endtask

  task automatic check_idle(input string nm);
    n_vec++;
    if (bus.led_out !== '0 || bus.hb_tick !== 1'b0) begin
      n_err++;
      $display("FAIL %s: led_out=%b hb_tick=%b, want led_out=0 hb_tick=0",
               nm, bus.led_out, bus.hb_tick);
    end
  endtask

  // Monitor: one expected entry per rising edge, compared mid-cycle.
  always @(negedge bd_fclk0_125m) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_vec++;
      if (bus.led_out !== x.led || bus.hb_tick !== x.tick) begin
        n_err++;
        $display("FAIL vec%0d t=%0t: led_out=%b hb_tick=%b, want led_out=%b hb_tick=%b",
                 n_vec, $time, bus.led_out, bus.hb_tick, x.led, x.tick);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold [NUM_CH];
    bus.ch_mode  = 4'b0100;
    bus.ch_act   = '0;
    bus.pwm_duty = 4'd4;
    model_reset();

    // Reset state while held in reset.
    #17;
    check_idle("reset_state");
    #5;
    bd_aresetn = 1'b1;

    // ch1 steady on, ch0 off; heartbeat tick after 16 edges.
    cycle(20);

    // ch0 blink locked to the heartbeat MSB.
    bus.ch_mode = 4'b0010;
    cycle(40);

    // ch0 activity: lone pulse, then a pulse re-armed during GAP.
    bus.ch_mode = 4'b0011;
    cycle(1);
    bus.ch_act = 2'b01; cycle(1); bus.ch_act = 2'b00;
    cycle(12);
    bus.ch_act = 2'b01; cycle(1); bus.ch_act = 2'b00;
    cycle(5);
    bus.ch_act = 2'b01; cycle(1); bus.ch_act = 2'b00;
    cycle(20);

    // Held request gives a repeating ON/GAP pattern.
    bus.ch_act = 2'b01; cycle(24); bus.ch_act = 2'b00;
    cycle(10);

    // Asynchronous reset between edges while ch0 is ON.
    bus.ch_act = 2'b01; cycle(1); bus.ch_act = 2'b00;
    cycle(2);
    #5;
    bd_aresetn = 1'b0;
    #1;
    check_idle("async_reset_mid_on");
    #1;
    bd_aresetn = 1'b1;
    model_reset();
    cycle(6);
    bus.ch_act = 2'b01; cycle(1); bus.ch_act = 2'b00;
    cycle(12);

    // Randomized modes, sparse and held requests, duty changes.
    for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 39) == 0)
          bus.ch_mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if (hold[c] > 0) begin
          hold[c]--;
          bus.ch_act[c] = 1'b1;
        end else if ($urandom_range(0, 29) == 0) begin
          hold[c] = $urandom_range(1, 12);
          bus.ch_act[c] = 1'b1;
        end else begin
          bus.ch_act[c] = ($urandom_range(0, 9) == 0);
        end
      end
      if ($urandom_range(0, 99) == 0) bus.pwm_duty = 4'($urandom_range(0, PW - 1));
      cycle(1);
    end

    // Drain and ensure every expectation was checked.
    bus.ch_act = '0;
    @(negedge bd_fclk0_125m);
    @(negedge bd_fclk0_125m);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
Parametrised multi-channel status-LED / PMOD driver for the OneTSwitch PL, built on a shared free-running heartbeat counter.
Each channel selects off, steady-on, heartbeat-blink or stretched-activity mode, so short events such as link or packet pulses become visible on pl_led/pl_pmod.
Sits in the top level beside the block design, clocked from the 125 MHz fabric clock.

Parameters:
NUM_CH, 4, number of LED/PMOD channels (>=1)
CNT_W, 24, heartbeat counter width; blink phase = hb_cnt[CNT_W-1]
STRETCH_CYC, 6250000, activity on-time and off-gap length in cycles (50 ms @125 MHz); must be >=2
PWM_W, 4, PWM counter/duty width (used only with LED_PWM_EN)

Ports:
bd_fclk0_125m  in  1  clock; all logic on the rising edge
bd_aresetn  in  1  reset, asynchronous, active-low
ch_mode  in  2*NUM_CH  per-channel mode, ch i in bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 activity
ch_act  in  NUM_CH  per-channel activity request, sampled every cycle
pwm_duty  in  PWM_W  global brightness duty; ignored unless LED_PWM_EN is defined
led_out  out  NUM_CH  registered LED drive
hb_tick  out  1  one-cycle pulse on each heartbeat counter wrap

Behaviour:
- Reset, asynchronous on bd_aresetn=0:
  - hb_cnt=0, all channel FSMs IDLE, timers=0, pend=0.
  - led_out=0, hb_tick=0; PWM counter=0 when compiled in.
  - Takes effect immediately, including mid-ON or mid-GAP.
- Heartbeat:
  - hb_cnt increments every cycle and wraps from 2^CNT_W-1 to 0.
  - hb_tick is registered: it is 1 in exactly the cycles where hb_cnt==0 after a wrap, never in the first cycle after reset release.
- Per-channel activity FSM; timer width is clog2(STRETCH_CYC).
  - IDLE: ch_act=1 -> ON, timer loads STRETCH_CYC-1.
  - ON: timer decrements each cycle. At timer==0 -> GAP, timer reloads STRETCH_CYC-1. ch_act during ON is ignored (no extension).
  - GAP: ch_act=1 at any cycle sets pend. At timer==0 -> ON (reload, pend cleared) if pend or ch_act, else IDLE.
  - Result: ON and GAP each last exactly STRETCH_CYC cycles.
  - When ch_mode!=11 the channel FSM is held in IDLE with timer=0 and pend=0. On entering mode 11 it starts from IDLE.
- Output mapping, registered; base_i computed from current state/counter, led_out updated on the next edge:
  - 00 -> 0
  - 01 -> 1
  - 10 -> hb_cnt[CNT_W-1]
  - 11 -> (state==ON)
- Latencies:
  - Mode change to led_out: 1 cycle.
  - ch_act sampled in IDLE at edge t: state=ON after edge t, led_out=1 after edge t+1.
- Channels are fully independent.
- Simultaneous ch_act and the GAP timer expiry counts as pending -> ON.

Optional Feature:
LED_PWM_EN:
- Defined:
  - Adds a free-running PWM_W-bit counter pwm_cnt.
  - led_out_i = base_i & ((pwm_cnt < pwm_duty) | (pwm_duty == all-ones)).
  - duty=0 gives always off; duty=all-ones gives full on.
  - Gating is applied before the output register, so latency is unchanged.
- Not defined: no PWM counter, pwm_duty unused, led_out_i = base_i.

Test Plan:
- Use NUM_CH=2, CNT_W=4, STRETCH_CYC=4, PWM_W=4 unless stated.
- Reset release with ch_mode=01_00 -> led_out=2'b10 one cycle after release edge; led_out[0] stays 0; hb_tick first high 16 cycles after release.
- ch_mode[1:0]=10 -> led_out[0] alternates 8 cycles low / 8 cycles high, locked to hb_cnt[3]; hb_tick is a 1-cycle pulse every 16 cycles.
- Mode 11, single 1-cycle ch_act[0] at edge t -> led_out[0]=1 for exactly 4 cycles starting after edge t+1, then 0. A second pulse during GAP restarts ON right at GAP end; with no second pulse the FSM returns to IDLE.
- Mode 11, ch_act[0] held high -> repeating 4 high / 4 low pattern on led_out[0]; ch1 in mode 00 stays 0 throughout.
- bd_aresetn pulsed low (no clock edge) while ch0 is in ON -> led_out=0 immediately. After release, ch_act=0 keeps led_out[0]=0; the next ch_act gives a fresh 4-cycle ON.
- With LED_PWM_EN, mode 01, pwm_duty=4 -> led_out[0] high 4 of every 16 cycles. pwm_duty=15 -> constantly high. pwm_duty=0 -> constantly low.
